// File: rtl/ram_fifo_ctrl_if.sv
// Client handshake and dual-port RAM connection bundle for ram_fifo_ctrl.
// i_Err_Clr / o_Overflow / o_Underflow exist only with RAM_FIFO_CTRL_ERR_FLAGS_EN.
interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_Wr_DV;
  logic [WIDTH-1:0] i_Wr_Data;
  logic             i_Rd_En;
  logic             o_Rd_DV;
  logic [WIDTH-1:0] o_Rd_Data;
  logic             o_Full;
  logic             o_Empty;
  logic             o_AF;
  logic             o_AE;
  logic [CW-1:0]    o_Count;
  logic [AW-1:0]    o_PortA_Addr;
  logic [WIDTH-1:0] o_PortA_Data;
  logic             o_PortA_WE;
  logic [AW-1:0]    o_PortB_Addr;
  logic [WIDTH-1:0] o_PortB_Data;
  logic             o_PortB_WE;
  logic [WIDTH-1:0] i_PortB_Data;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
  logic             i_Err_Clr;
  logic             o_Overflow;
  logic             o_Underflow;

  modport slave (
    input  i_Wr_DV, i_Wr_Data, i_Rd_En, i_PortB_Data, i_Err_Clr,
    output o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_AF, o_AE, o_Count,
           o_PortA_Addr, o_PortA_Data, o_PortA_WE,
           o_PortB_Addr, o_PortB_Data, o_PortB_WE,
           o_Overflow, o_Underflow
  );

  modport master (
    output i_Wr_DV, i_Wr_Data, i_Rd_En, i_PortB_Data, i_Err_Clr,
    input  o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_AF, o_AE, o_Count,
           o_PortA_Addr, o_PortA_Data, o_PortA_WE,
           o_PortB_Addr, o_PortB_Data, o_PortB_WE,
           o_Overflow, o_Underflow
  );
`else
  modport slave (
    input  i_Wr_DV, i_Wr_Data, i_Rd_En, i_PortB_Data,
    output o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_AF, o_AE, o_Count,
           o_PortA_Addr, o_PortA_Data, o_PortA_WE,
           o_PortB_Addr, o_PortB_Data, o_PortB_WE
  );

  modport master (
    output i_Wr_DV, i_Wr_Data, i_Rd_En, i_PortB_Data,
    input  o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_AF, o_AE, o_Count,
           o_PortA_Addr, o_PortA_Data, o_PortA_WE,
           o_PortB_Addr, o_PortB_Data, o_PortB_WE
  );
`endif
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-clock dual-port RAM (port A write, port B read).
// Define RAM_FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module ram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  ram_fifo_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1'b1);
    end
  endfunction

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          af_q,     af_d;
  logic          ae_q,     ae_d;
  logic          rd_dv_q,  rd_dv_d;
  logic          wr_acc_s;
  logic          rd_acc_s;

  // Acceptance uses only registered flags, so no input-to-input loop exists.
  always_comb begin
    wr_acc_s = bus.i_Wr_DV & ~full_q;
    rd_acc_s = bus.i_Rd_En & ~empty_q;
  end

  // Next-state for pointers, fill count, decoded flags and read-valid.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    // Flags are registered copies of the decode of the next count.
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == {CW{1'b0}});
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
    rd_dv_d = rd_acc_s;
  end

  // State registers; reset discards contents and any in-flight read strobe.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rd_dv_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      rd_dv_q  <= rd_dv_d;
    end
  end

  assign bus.o_Full       = full_q;
  assign bus.o_Empty      = empty_q;
  assign bus.o_AF         = af_q;
  assign bus.o_AE         = ae_q;
  assign bus.o_Count      = count_q;
  assign bus.o_Rd_DV      = rd_dv_q;
  // RAM output register already holds the word; pass it straight through.
  assign bus.o_Rd_Data    = bus.i_PortB_Data;

  assign bus.o_PortA_WE   = wr_acc_s;
  assign bus.o_PortA_Addr = wr_ptr_q;
  assign bus.o_PortA_Data = bus.i_Wr_Data;
  assign bus.o_PortB_Addr = rd_ptr_q;
  assign bus.o_PortB_Data = {WIDTH{1'b0}};
  assign bus.o_PortB_WE   = 1'b0;

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; a new error wins over a coincident clear.
  always_comb begin
    if (bus.i_Wr_DV && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.i_Err_Clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (bus.i_Rd_En && empty_q) begin
      unf_d = 1'b1;
    end else if (bus.i_Err_Clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.o_Overflow  = ovf_q;
  assign bus.o_Underflow = unf_q;
`endif

endmodule
